wb_arbiter: RTL

- Writeback stage directly upstream of the register file write port.
- Merges two result sources into the single write port:
  - the in-order pipeline writeback, which has fixed priority and is never stalled;
  - a long-latency return stream (multiply/divide, load miss) using a valid/ready handshake.
- Long-latency results that cannot be written immediately are held in a small FIFO.
- Outputs are registered and drive the register file write enable, write select and write data.

---
 rtl/wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the in-order pipeline result and the long-latency
// return stream onto the single register file write port.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              lat_valid,
    input  logic [REG_AW-1:0] lat_rd,
    input  logic [DATA_W-1:0] lat_data,
    output logic              lat_ready,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_wsel,
    output logic [DATA_W-1:0] rf_wdat,
    output logic [CNT_W-1:0]  fifo_count
);

    localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [REG_AW-1:0] mem_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic wb_live;
    logic lat_live;
    logic fifo_empty;
    logic sel_wb;
    logic sel_fifo;
    logic sel_byp;
    logic push;
    logic pop;

    // Ready depends only on the registered count so upstream never sees a
    // combinational path from its own valid back to ready.
    assign lat_ready  = nRST && (fifo_count < DEPTH_C);

    assign wb_live    = wb_valid && (wb_rd != '0);
    assign lat_live   = lat_valid && lat_ready && (lat_rd != '0);
    assign fifo_empty = (fifo_count == '0);

    assign sel_wb     = wb_live;
    assign sel_fifo   = !wb_live && !fifo_empty;
    assign sel_byp    = !wb_live && fifo_empty && lat_live;

    assign push       = lat_live && !sel_byp;
    assign pop        = sel_fifo;

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_rd[wr_ptr]   <= lat_rd;
            mem_data[wr_ptr] <= lat_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    // Select/data hold their last value when no write is issued.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rf_wen  <= 1'b0;
            rf_wsel <= '0;
            rf_wdat <= '0;
        end else begin
            rf_wen <= sel_wb || sel_fifo || sel_byp;
            if (sel_wb) begin
                rf_wsel <= wb_rd;
                rf_wdat <= wb_data;
            end else if (sel_fifo) begin
                rf_wsel <= mem_rd[rd_ptr];
                rf_wdat <= mem_data[rd_ptr];
            end else if (sel_byp) begin
                rf_wsel <= lat_rd;
                rf_wdat <= lat_data;
            end
        end
    end

endmodule
